// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: instruction decode
// fields, funct3 op codes, FSM state encoding and iteration counter width.
package muldiv_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/exe_muldiv_iter.sv
// One radix-2 step of the iterative datapath: shift-add multiply on a
// {hi,lo} 64-bit accumulator, or restoring shift-subtract divide with
// hi = partial remainder and lo = dividend shifting into the quotient.
module exe_muldiv_iter (
  input  logic        is_div_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] operand_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic [32:0] diff;

  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, operand_i} : 33'd0);
    shifted = {hi_i, lo_i[31]};
    diff    = shifted - {1'b0, operand_i};
    if (is_div_i) begin
      // diff[32] set means the trial subtract went negative: restore
      if (!diff[32]) begin
        hi_o = diff[31:0];
        lo_o = {lo_i[30:0], 1'b1};
      end else begin
        hi_o = shifted[31:0];
        lo_o = {lo_i[30:0], 1'b0};
      end
    end else begin
      hi_o = sum[32:1];
      lo_o = {sum[0], lo_i[31:1]};
    end
  end

endmodule

// File: rtl/exe_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage. Defining
// MULDIV_FAST_MUL_EN replaces the 32-step multiply with a single-cycle product.
module exe_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            kill_i,
  input  logic [XLEN-1:0] exe_read_data_a_i,
  input  logic [XLEN-1:0] exe_read_data_b_i,
  input  logic [XLEN-1:0] exe_write_addr_i,
  input  logic [XLEN-1:0] exe_instruction_i,
  output logic            muldiv_busy_o,
  output logic            muldiv_valid_o,
  output logic [XLEN-1:0] muldiv_result_o,
  output logic [XLEN-1:0] muldiv_write_addr_o,
  output logic            muldiv_int_write_enable_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, waddr_q, waddr_d;
  logic               neg_q, neg_d;

  logic [31:0] a, b, a_abs, b_abs, step_hi, step_lo, div_sel, res;
  logic [63:0] full, mul_res;
  logic [2:0]  f3;
  logic        is_m, a_signed, b_signed, neg_issue, div_ovf, valid;

  assign a    = exe_read_data_a_i;
  assign b    = exe_read_data_b_i;
  assign f3   = exe_instruction_i[14:12];
  assign is_m = (exe_instruction_i[6:0] == OPCODE_OP) &&
                (exe_instruction_i[31:25] == FUNCT7_MULDIV);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [65:0] fast_prod;
  logic               unused_bits;
  assign fast_prod   = $signed({a_signed & a[31], a}) * $signed({b_signed & b[31], b});
  assign unused_bits = ^{exe_instruction_i[24:15], exe_instruction_i[11:7], fast_prod[65:64]};
`else
  logic unused_bits;
  assign unused_bits = ^{exe_instruction_i[24:15], exe_instruction_i[11:7]};
`endif

  // REM negates by the dividend sign only; the quotient/product by sign(a)^sign(b)
  always_comb begin
    a_signed  = (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    b_signed  = (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    a_abs     = (a_signed && a[31]) ? -a : a;
    b_abs     = (b_signed && b[31]) ? -b : b;
    neg_issue = (a_signed & a[31]) ^ (b_signed & b[31] & (f3 != F3_REM));
    div_ovf   = (f3 == F3_DIV || f3 == F3_REM) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  end

  exe_muldiv_iter u_iter (
    .is_div_i  (op_q[2]),
    .hi_i      (hi_q),
    .lo_i      (lo_q),
    .operand_i (opnd_q),
    .hi_o      (step_hi),
    .lo_o      (step_lo)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      waddr_q <= waddr_d;
    end
  end

  // Special-case divides preload the final quotient/remainder and skip BUSY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    waddr_d = waddr_q;
    if (kill_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_m) begin
            op_d    = f3;
            waddr_d = exe_write_addr_i;
            cnt_d   = '0;
            neg_d   = neg_issue;
            hi_d    = '0;
            state_d = ST_BUSY;
            if (f3[2]) begin
              lo_d   = a_abs;
              opnd_d = b_abs;
              if (b == 32'd0) begin
                hi_d    = a;
                lo_d    = 32'hFFFF_FFFF;
                neg_d   = 1'b0;
                state_d = ST_DONE;
              end else if (div_ovf) begin
                lo_d    = 32'h8000_0000;
                neg_d   = 1'b0;
                state_d = ST_DONE;
              end
            end else begin
              lo_d   = b_abs;
              opnd_d = a_abs;
`ifdef MULDIV_FAST_MUL_EN
              hi_d    = fast_prod[63:32];
              lo_d    = fast_prod[31:0];
              neg_d   = 1'b0;
              state_d = ST_DONE;
`endif
            end
          end
        end
        ST_BUSY: begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    full    = {hi_q, lo_q};
    mul_res = neg_q ? -full : full;
    div_sel = op_q[1] ? hi_q : lo_q;
    if (op_q[2])              res = neg_q ? -div_sel : div_sel;
    else if (op_q == F3_MUL)  res = mul_res[31:0];
    else                      res = mul_res[63:32];
    valid                     = (state_q == ST_DONE) && !rst_i && !kill_i;
    muldiv_valid_o            = valid;
    muldiv_int_write_enable_o = valid;
    muldiv_result_o           = valid ? res : '0;
    muldiv_write_addr_o       = waddr_q;
    muldiv_busy_o             = !rst_i && !kill_i &&
                                (((state_q == ST_IDLE) && is_m) || (state_q == ST_BUSY));
  end

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed self-checking bench for exe_muldiv; honours MULDIV_FAST_MUL_EN
// for the expected multiply latency.
module tb_exe_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, kill;
  logic [31:0] opA, opB, waddrIn, instr;
  logic        busyO, validO, wenO;
  logic [31:0] resultO, waddrO;

  int total = 0;
  int bad   = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  always #5 clk = ~clk;

  exe_muldiv #(.XLEN(32)) dut (
    .clk_i                     (clk),
    .rst_i                     (rst),
    .kill_i                    (kill),
    .exe_read_data_a_i         (opA),
    .exe_read_data_b_i         (opB),
    .exe_write_addr_i          (waddrIn),
    .exe_instruction_i         (instr),
    .muldiv_busy_o             (busyO),
    .muldiv_valid_o            (validO),
    .muldiv_result_o           (resultO),
    .muldiv_write_addr_o       (waddrO),
    .muldiv_int_write_enable_o (wenO)
  );

  function automatic logic [31:0] mkInstr(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] wa);
    instr   = mkInstr(FUNCT7_MULDIV, f3);
    opA     = a;
    opB     = b;
    waddrIn = wa;
  endtask

  task automatic nop();
    instr = mkInstr(7'b0000000, 3'd0);
    opA   = 32'd11;
    opB   = 32'd22;
  endtask

  task automatic waitValid(output int cyc, output int busyCnt);
    cyc     = 0;
    busyCnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busyO && !validO) busyCnt++;
    end while (!validO && cyc < 80);
  endtask

  task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] wa,
                               input logic [31:0] exp, input int expLat);
    int cyc, busyCnt;
    @(negedge clk);
    issue(f3, a, b, wa);
    #1;
    checkOutput({tag, " busyT0"}, {31'b0, busyO}, 32'd1);
    waitValid(cyc, busyCnt);
    checkOutput({tag, " latency"}, cyc, expLat);
    checkOutput({tag, " busyCycles"}, busyCnt, expLat - 1);
    checkOutput({tag, " result"}, resultO, exp);
    checkOutput({tag, " waddr"}, waddrO, wa);
    checkOutput({tag, " busyDone"}, {31'b0, busyO}, 32'd0);
    checkOutput({tag, " wen"}, {31'b0, wenO}, 32'd1);
    nop();
    @(negedge clk);
    checkOutput({tag, " validDrop"}, {31'b0, validO}, 32'd0);
  endtask

  initial begin
    int cyc, busyCnt, pulses;
    rst  = 1'b1;
    kill = 1'b0;
    issue(F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", {31'b0, busyO}, 32'd0);
    checkOutput("rstValid", {31'b0, validO}, 32'd0);
    rst = 1'b0;
    nop();
    @(negedge clk);
    checkOutput("idleResult", resultO, 32'd0);
    checkOutput("idleWaddr", waddrO, 32'd0);
    checkOutput("idleBusy", {31'b0, busyO}, 32'd0);

    applyStimulus("MUL", F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFEB, MUL_LAT);
    applyStimulus("MULHU", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd6, 32'hFFFF_FFFE, MUL_LAT);
    applyStimulus("MULH", F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd0, MUL_LAT);
    applyStimulus("MULHSU", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd8, 32'hFFFF_FFFF, MUL_LAT);
    applyStimulus("MULHmin", F3_MULH, 32'h8000_0000, 32'h8000_0000, 32'd9, 32'h4000_0000, MUL_LAT);
    applyStimulus("DIV", F3_DIV, 32'hFFFF_FFEC, 32'd6, 32'd10, 32'hFFFF_FFFD, DIV_LAT);
    applyStimulus("REM", F3_REM, 32'hFFFF_FFEC, 32'd6, 32'd11, 32'hFFFF_FFFE, DIV_LAT);
    applyStimulus("DIVU", F3_DIVU, 32'd20, 32'd6, 32'd12, 32'd3, DIV_LAT);
    applyStimulus("REMU", F3_REMU, 32'd20, 32'd6, 32'd13, 32'd2, DIV_LAT);
    applyStimulus("DIVUmax", F3_DIVU, 32'hFFFF_FFFF, 32'd1, 32'd14, 32'hFFFF_FFFF, DIV_LAT);
    applyStimulus("DIVUz", F3_DIVU, 32'd5, 32'd0, 32'd15, 32'hFFFF_FFFF, 1);
    applyStimulus("REMUz", F3_REMU, 32'd5, 32'd0, 32'd16, 32'd5, 1);
    applyStimulus("REMz", F3_REM, 32'hFFFF_FFF9, 32'd0, 32'd17, 32'hFFFF_FFF9, 1);
    applyStimulus("DIVovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd18, 32'h8000_0000, 1);
    applyStimulus("REMovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd19, 32'd0, 1);

    // kill in the middle of a divide: flushed, never produces a result
    @(negedge clk);
    issue(F3_DIV, 32'hFFFF_FFEC, 32'd6, 32'd20);
    repeat (10) @(negedge clk);
    kill = 1'b1;
    nop();
    #1;
    checkOutput("killBusy", {31'b0, busyO}, 32'd0);
    @(negedge clk);
    kill = 1'b0;
    checkOutput("killT11Valid", {31'b0, validO}, 32'd0);
    checkOutput("killT11Busy", {31'b0, busyO}, 32'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (validO || busyO) pulses++;
    end
    checkOutput("killAddQuiet", pulses, 32'd0);
    applyStimulus("DIVUpostKill", F3_DIVU, 32'd100, 32'd7, 32'd21, 32'd14, DIV_LAT);

    // reset mid-BUSY, then two back-to-back multiplies
    @(negedge clk);
    issue(F3_MUL, 32'd3, 32'd3, 32'd22);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midRstBusy", {31'b0, busyO}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nop();
    @(negedge clk);
    checkOutput("postRstValid", {31'b0, validO}, 32'd0);
    checkOutput("postRstResult", resultO, 32'd0);
    checkOutput("postRstWaddr", waddrO, 32'd0);
    checkOutput("postRstBusy", {31'b0, busyO}, 32'd0);
    issue(F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'd23);
    waitValid(cyc, busyCnt);
    checkOutput("b2b1 latency", cyc, MUL_LAT);
    checkOutput("b2b1 result", resultO, 32'hFFFF_FFEB);
    checkOutput("b2b1 waddr", waddrO, 32'd23);
    issue(F3_MUL, 32'd6, 32'd7, 32'd24);
    waitValid(cyc, busyCnt);
    checkOutput("b2b2 spacing", cyc, MUL_LAT + 1);
    checkOutput("b2b2 result", resultO, 32'd42);
    checkOutput("b2b2 waddr", waddrO, 32'd24);
    nop();
    @(negedge clk);
    checkOutput("b2b validDrop", {31'b0, validO}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
